time_keeper: RTL and testbench
==============================

# time_keeper

Parametrised time-of-day core replacing the standalone hour counter: one block that divides `clk` down to seconds and cascades seconds, minutes and hours with wrap-around. It adds a load handshake with range checking, 12/24-hour display outputs and registered carry pulses (second, minute, hour, day). It sits between the board clock and the display/alarm logic, and is the single source of time for the design.

## Interface
- `CLK_DIV`, 100_000_000, `clk` cycles per second (≥1)
- `clk` input 1: system clock, all logic on its rising edge
- `reset` input 1: synchronous, active-high
- `en` input 1: count enable; when low, the prescaler and counters hold
- `set_valid` input 1: load request
- `set_ready` output 1: block can accept a load
- `set_hour` input 5: load value, 0..23
- `set_min` input 6: load value, 0..59
- `set_sec` input 6: load value, 0..59
- `set_err` output 1: one-cycle pulse when a load is rejected
- `sec` output 6: seconds, 0..59
- `min` output 6: minutes, 0..59
- `hour` output 5: hours, 0..23
- `disp_hour` output 4: 12-hour form, 1..12
- `pm` output 1: `hour` ≥ 12
- `sec_tick`, `min_tick`, `hour_tick`, `day_tick` output 1 each: one-cycle carry pulses

## Operation
- Prescaler `pre` is $clog2(CLK_DIV) bits wide, minimum 1. It counts 0..CLK_DIV-1 while `en` is high. `wrap` = `en` && `pre` == CLK_DIV-1. With CLK_DIV=1, `wrap` = `en`.
- On `wrap`:
  - `sec` increments, or goes 59→0.
  - If `sec` was 59, `min` increments, or goes 59→0.
  - If `sec` and `min` were both 59, `hour` increments, or goes 23→0.
- FSM states:
  - RUN: `set_ready`=1.
  - LOAD: `set_ready`=0, lasts exactly one cycle, then returns to RUN.
- Load is accepted on `set_valid` && `set_ready`.
  - If all fields are in range: load `sec`/`min`/`hour`, clear `pre`, go to LOAD.
  - If any field is out of range: counters unchanged, `set_err`=1 next cycle, stay in RUN.
- An accepted load on a `wrap` cycle: the load wins, the increment is discarded and no ticks are generated.
- `en` low during LOAD: LOAD still completes. `set_valid` is honoured regardless of `en`.
- `disp_hour`: 12 when `hour`=0; `hour`-12 when `hour`>12; otherwise `hour`. This is combinational from the registered `hour`.
- `pm` = (`hour` ≥ 12), combinational.

## Timing
- Reset values:
  - `pre`, `sec`, `min`, `hour` = 0
  - FSM = RUN, `set_ready`=1
  - all ticks = 0, `set_err` = 0
  - therefore `disp_hour`=12, `pm`=0
- Counters update on the same edge as `wrap`.
- Tick outputs are registered and high for exactly the one cycle after that edge. They are therefore aligned with the new counter values.
  - `sec_tick` on every `wrap`.
  - `min_tick` when `sec` wrapped 59→0.
  - `hour_tick` when `min` also wrapped.
  - `day_tick` when `hour` also wrapped 23→0.
- Load latency: new values are visible the cycle after acceptance. The next `wrap` follows exactly CLK_DIV enabled cycles later.
- `set_ready` falls the cycle after acceptance and rises one cycle later.
- `reset` mid-operation (including during LOAD) overrides everything on that edge.

## Structure
- Package `time_pkg`:
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - SEC_W=6, MIN_W=6, HOUR_W=5
  - FSM state enum {RUN, LOAD}
- Sub-module `mod_counter`:
  - parameters MAX, W
  - inputs: `inc`, `load`, `load_val`
  - outputs: `q`, `carry` (`inc` && `q`==MAX)
  - `load` has priority over `inc`
  - instantiated for sec/min/hour, with carries chained as `inc` of the next stage
- Prescaler, FSM, range check, tick registers and 12h mapping live in `time_keeper`.

## Test plan
All tests use CLK_DIV=4.
- Reset, then `en`=1 for 8 cycles → `sec`=2. `sec_tick` pulses twice, 4 cycles apart; after reset `disp_hour`=12, `pm`=0.
- Load 23:59:58 (`set_valid` one cycle) → next cycle 23:59:58 and `set_ready`=0 for one cycle. After 8 more cycles → 00:00:00, with `min_tick`, `hour_tick` and `day_tick` all high in the same single cycle.
- Load `set_min`=60 → `set_err` pulses one cycle; time is unchanged; `set_ready` stays 1.
- Assert a valid load 12:00:00 on the exact `wrap` cycle → time reads 12:00:00, no `sec_tick`, `disp_hour`=12, `pm`=1. Then load 13:05:00 → `disp_hour`=1, `pm`=1.
- With `en`=0 for 10 cycles mid-count → `pre` and time frozen, no ticks. Resume → next `sec_tick` occurs after the remaining prescaler count.
- Assert `reset` during LOAD → next cycle all outputs at reset values and `set_ready`=1.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants and types for the time-of-day core.
//   SEC/MIN/HOUR_MAX : last value of each field before it wraps to zero
//   SEC/MIN/HOUR_W   : field widths
//   state_t          : load-handshake FSM state
package time_pkg;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with synchronous load, used for each time-of-day field.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   inc             : advance by one (wraps MAX -> 0)
//   load, load_val  : load a new value; load has priority over inc
//   q               : current value
//   carry           : inc while q == MAX (feeds inc of the next stage)
module mod_counter
  import time_pkg::*;
#(
  parameter int unsigned MAX = SEC_MAX,
  parameter int unsigned W   = SEC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = (r_q == W'(MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (inc) begin
      r_q <= w_at_max ? '0 : r_q + W'(1);
    end
  end

  assign q     = r_q;
  assign carry = inc && w_at_max;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day core: divides clk down to seconds and cascades sec/min/hour
// with wrap-around, a range-checked load handshake, 12-hour display outputs
// and registered carry pulses.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   en                          : count enable (prescaler and counters hold when low)
//   set_valid/set_ready         : load handshake
//   set_hour/set_min/set_sec    : load values
//   set_err                     : one-cycle pulse when a load is rejected
//   sec/min/hour                : current time (24-hour)
//   disp_hour, pm               : 12-hour form of hour
//   sec/min/hour/day_tick       : one-cycle carry pulses, aligned with new values
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_err,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [3:0]        disp_hour,
  output logic              pm,
  output logic              sec_tick,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              day_tick
);

  localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  state_t           r_state, w_state_d;
  logic             r_sec_tick, r_min_tick, r_hour_tick, r_day_tick, r_set_err;

  logic w_wrap, w_in_range, w_accept, w_load, w_reject, w_sec_inc;
  logic w_sec_carry, w_min_carry, w_hour_carry;

  assign set_ready  = (r_state == RUN);
  assign w_wrap     = en && (r_pre == PRE_LAST);
  assign w_in_range = (set_hour <= HOUR_W'(HOUR_MAX)) && (set_min <= MIN_W'(MIN_MAX)) &&
                      (set_sec <= SEC_W'(SEC_MAX));
  assign w_accept   = set_valid && set_ready;
  assign w_load     = w_accept && w_in_range;
  assign w_reject   = w_accept && !w_in_range;
  // A load on a wrap cycle discards the increment, so no carries or ticks either.
  assign w_sec_inc  = w_wrap && !w_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_load) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_wrap ? '0 : r_pre + PRE_W'(1);
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_sec_inc),
    .load     (w_load),
    .load_val (set_sec),
    .q        (sec),
    .carry    (w_sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_sec_carry),
    .load     (w_load),
    .load_val (set_min),
    .q        (min),
    .carry    (w_min_carry)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_min_carry),
    .load     (w_load),
    .load_val (set_hour),
    .q        (hour),
    .carry    (w_hour_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      RUN:     if (w_load) w_state_d = LOAD;
      LOAD:    w_state_d = RUN;
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_sec_tick  <= w_sec_inc;
      r_min_tick  <= w_sec_carry;
      r_hour_tick <= w_min_carry;
      r_day_tick  <= w_hour_carry;
      r_set_err   <= w_reject;
    end
  end

  assign sec_tick  = r_sec_tick;
  assign min_tick  = r_min_tick;
  assign hour_tick = r_hour_tick;
  assign day_tick  = r_day_tick;
  assign set_err   = r_set_err;

  // 12-hour mapping: 0 -> 12, 13..23 -> 1..11.
  always_comb begin
    disp_hour = 4'(hour);
    if (hour == '0) begin
      disp_hour = 4'd12;
    end else if (hour > HOUR_W'(12)) begin
      disp_hour = 4'(hour - HOUR_W'(12));
    end
  end

  assign pm = (hour >= HOUR_W'(12));

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with CLK_DIV=4.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset, en, set_valid, set_ready, set_err;
  logic [4:0] set_hour, hour;
  logic [5:0] set_min, set_sec, sec, min;
  logic [3:0] disp_hour;
  logic       pm, sec_tick, min_tick, hour_tick, day_tick;

  int checks = 0;
  int errors = 0;

  time_keeper #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_err   (set_err),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .disp_hour (disp_hour),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .day_tick  (day_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sv;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [5:0] ss;
    int         eh;
    int         em;
    int         es;
    int         ed;
    logic       epm;
    logic       erdy;
    logic       eerr;
    logic [3:0] etk;  // {sec, min, hour, day}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic e, logic s, int h_in, int m_in, int s_in, int eh, int em,
                             int es, int ed, logic epm, logic erdy, logic eerr, logic [3:0] etk);
    vec_t r;
    r.en = e; r.sv = s; r.sh = 5'(h_in); r.sm = 6'(m_in); r.ss = 6'(s_in);
    r.eh = eh; r.em = em; r.es = es; r.ed = ed;
    r.epm = epm; r.erdy = erdy; r.eerr = eerr; r.etk = etk;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(string tag, int eh, int em, int es, int ed, logic epm, logic erdy,
                           logic eerr, logic [3:0] etk);
    chk({tag, " hour"}, 32'(hour), eh);
    chk({tag, " min"}, 32'(min), em);
    chk({tag, " sec"}, 32'(sec), es);
    chk({tag, " disp_hour"}, 32'(disp_hour), ed);
    chk({tag, " pm"}, 32'(pm), int'(epm));
    chk({tag, " set_ready"}, 32'(set_ready), int'(erdy));
    chk({tag, " set_err"}, 32'(set_err), int'(eerr));
    chk({tag, " ticks"}, 32'({sec_tick, min_tick, hour_tick, day_tick}), int'(etk));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; set_valid = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;

    // Count from reset: sec_tick every 4 enabled cycles.
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 0, 4'b1000));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 2, 12, 0, 1, 0, 4'b1000));
    // Load 23:59:58, then roll over into the next day.
    vecs.push_back(v(1, 1, 23, 59, 58, 23, 59, 58, 11, 1, 0, 0, 4'b0000));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 0, 0, 0, 0, 23, 59, 58, 11, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 23, 59, 59, 11, 1, 1, 0, 4'b1000));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 0, 0, 0, 0, 23, 59, 59, 11, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 4'b1111));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 4'b0000));
    // Out-of-range minute is rejected.
    vecs.push_back(v(1, 1, 1, 60, 0, 0, 0, 0, 12, 0, 1, 1, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 4'b0000));
    // Valid load on the wrap cycle: load wins, no tick.
    vecs.push_back(v(1, 1, 12, 0, 0, 12, 0, 0, 12, 1, 0, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 12, 0, 0, 12, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 1, 13, 5, 0, 13, 5, 0, 1, 1, 0, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 13, 5, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 13, 5, 0, 1, 1, 1, 0, 4'b0000));
    // Hold with en low, then finish the remaining two prescaler counts.
    for (int i = 0; i < 10; i++) vecs.push_back(v(0, 0, 0, 0, 0, 13, 5, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 13, 5, 0, 1, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 0, 13, 5, 1, 1, 1, 1, 0, 4'b1000));

    cyc();
    cyc();
    check_out("reset", 0, 0, 0, 12, 0, 1, 0, 4'b0000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].en; set_valid = vecs[i].sv;
      set_hour = vecs[i].sh; set_min = vecs[i].sm; set_sec = vecs[i].ss;
      cyc();
      check_out($sformatf("row%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ed,
                vecs[i].epm, vecs[i].erdy, vecs[i].eerr, vecs[i].etk);
    end

    // Reset arriving while in LOAD overrides the pending return to RUN.
    set_valid = 1'b1; set_hour = 5'd10; set_min = 6'd20; set_sec = 6'd30;
    cyc();
    check_out("load10", 10, 20, 30, 10, 0, 0, 0, 4'b0000);
    set_valid = 1'b0; reset = 1'b1;
    cyc();
    check_out("reset_in_load", 0, 0, 0, 12, 0, 1, 0, 4'b0000);
    reset = 1'b0; en = 1'b0;
    cyc();
    check_out("after_reset", 0, 0, 0, 12, 0, 1, 0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
